// File: rtl/adc_deser_width_fifo.sv
`default_nettype none
// ============================================================================
// adc_deser_width_fifo
// Width-converting sample FIFO: WIDTH_IN-bit frames in, WIDTH_OUT-bit slices
// out, least-significant slice first.
// Revision: 1.0
// ============================================================================
module adc_deser_width_fifo #(
  parameter int SAMPLE_W      = 12,
  parameter int DESER_FACTOR  = 8,
  parameter int WIDTH_IN      = SAMPLE_W * DESER_FACTOR,
  parameter int WIDTH_OUT     = 32,
  parameter int DEPTH_WORDS   = 128,
  parameter int RDY_THRESHOLD = DEPTH_WORDS / 2,
  parameter int RATIO         = WIDTH_IN / WIDTH_OUT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [WIDTH_IN-1:0]            wr_data,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output logic [WIDTH_OUT-1:0]           rd_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [$clog2(DEPTH_WORDS):0]   wr_level,
  output logic                           rdy_for_read,
  output logic                           overflow,
  input  logic                           ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH_WORDS);
  localparam int LVL_W = PTR_W + 1;
  localparam int SLC_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (WIDTH_IN % WIDTH_OUT != 0) begin : g_bad_ratio
    $error("WIDTH_IN must be an integer multiple of WIDTH_OUT");
  end
  if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of 2 and at least 4");
  end

  logic [WIDTH_IN-1:0]  mem [DEPTH_WORDS];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [SLC_W-1:0]     slice_idx;
  logic [LVL_W-1:0]     level_next;
  logic [WIDTH_IN-1:0]  cur_word;
  logic [WIDTH_OUT-1:0] slices [RATIO];
  logic                 accept;
  logic                 load;
  logic                 rel;
  logic                 last_slice;
  logic                 ovf_set;

  assign cur_word = mem[rd_ptr];

  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slices[g] = cur_word[g*WIDTH_OUT +: WIDTH_OUT];
  end

  assign wr_ready   = (wr_level != LVL_W'(DEPTH_WORDS));
  assign accept     = wr_valid & wr_ready & ~flush;
  // The partially sliced entry is still counted, so level != 0 means data.
  assign load       = (~rd_valid | rd_ready) & (wr_level != '0) & ~flush;
  assign last_slice = (slice_idx == SLC_W'(RATIO - 1));
  assign rel        = load & last_slice;
  assign ovf_set    = wr_valid & ~wr_ready & ~flush;

  always_comb begin
    level_next = wr_level;
    if (accept && !rel) begin
      level_next = wr_level + 1'b1;
    end else if (!accept && rel) begin
      level_next = wr_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      slice_idx    <= '0;
      wr_level     <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rdy_for_read <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // Set wins over clear when both happen together.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      if (flush) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        slice_idx    <= '0;
        wr_level     <= '0;
        rd_valid     <= 1'b0;
        rdy_for_read <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (load) begin
          rd_data  <= slices[slice_idx];
          rd_valid <= 1'b1;
          if (last_slice) begin
            rd_ptr    <= rd_ptr + 1'b1;
            slice_idx <= '0;
          end else begin
            slice_idx <= slice_idx + 1'b1;
          end
        end else if (rd_ready) begin
          rd_valid <= 1'b0;
        end
        wr_level     <= level_next;
        rdy_for_read <= (level_next >= LVL_W'(RDY_THRESHOLD));
      end
    end
  end

endmodule
`default_nettype wire
